// File: rtl/icache_ctrl_pkg.sv
// Shared types and constants for the I-cache refill controller.
// No logic here, so there is no latency and no backpressure.
package icache_ctrl_pkg;

    localparam int LINE_WORDS      = 4;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/miss_pri_enc4.sv
// Finds the lowest set bit of a 4-bit miss mask. This block is purely combinational.
// It takes no handshake; found is low when the mask is empty.
module miss_pri_enc4 (
    input  logic [3:0] mask,
    output logic [1:0] idx,
    output logic       found
);

    always_comb begin
        idx   = 2'd0;
        found = |mask;
        if (mask[0])      idx = 2'd0;
        else if (mask[1]) idx = 2'd1;
        else if (mask[2]) idx = 2'd2;
        else if (mask[3]) idx = 2'd3;
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Refills the missing words of a 4-word fetch group from L2, one word at a time. Each word takes 3 cycles when L2 responds immediately.
// Fetch is stalled while the controller is busy; L2 backpressure is handled by holding the request until l2_ack.
module icache_refill_ctrl #(
    parameter int TIMEOUT_CYC = icache_ctrl_pkg::TIMEOUT_CYC_DEF,
    parameter int LINE_WORDS  = icache_ctrl_pkg::LINE_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [63:0] fetch_addr,
    input  logic [3:0]  hit,
    output logic        fetch_stall,
    output logic        l2_req,
    output logic [63:0] l2_addr,
    input  logic        l2_ack,
    input  logic        l2_rvalid,
    input  logic [63:0] l2_rdata,
    output logic        fill_start,
    output logic [63:0] fill_addr,
    output logic [63:0] fill_data,
    output logic        refill_done,
    output logic        refill_err,
    output logic        busy
);
    import icache_ctrl_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t                  state_q, state_d;
    logic [63:0]             base_q;
    logic [LINE_WORDS-1:0]   mask_q, mask_clr;
    logic [CNT_W-1:0]        cnt_q;
    logic [63:0]             data_q;
    logic                    err_q;
    logic [1:0]              k;
    logic                    pend_vld;
    logic                    miss;
    logic                    timeout;

    miss_pri_enc4 u_pri (
        .mask  (mask_q),
        .idx   (k),
        .found (pend_vld)
    );

    assign miss     = fetch_valid && (hit != 4'hF);
    assign mask_clr = mask_q & ~(LINE_WORDS'(1) << k);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= timeout;
            case (state_q)
                ST_IDLE: if (miss) begin
                    base_q <= fetch_addr;
                    mask_q <= ~hit;
                end
                ST_REQ:  if (l2_ack) cnt_q <= '0;
                ST_WAIT: begin
                    if (l2_rvalid)    data_q <= l2_rdata;
                    else if (timeout) mask_q <= '0;
                    else              cnt_q  <= cnt_q + 1'b1;
                end
                ST_FILL: mask_q <= mask_clr;
                default: ;
            endcase
        end
    end

    // Word-side outputs are decoded from the registered state, so a reset edge clears them all.
    always_comb begin
        state_d     = state_q;
        timeout     = 1'b0;
        l2_req      = 1'b0;
        l2_addr     = '0;
        fill_start  = 1'b0;
        fill_addr   = '0;
        fill_data   = '0;
        refill_done = 1'b0;
        case (state_q)
            ST_IDLE: if (miss) state_d = ST_REQ;
            ST_REQ: begin
                if (!pend_vld) begin
                    state_d = ST_DONE;
                end else begin
                    l2_req  = 1'b1;
                    l2_addr = base_q + 64'(k);
                    if (l2_ack) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (l2_rvalid) begin
                    state_d = ST_FILL;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                fill_start = 1'b1;
                fill_addr  = base_q + 64'(k);
                fill_data  = data_q;
                state_d    = (mask_clr != '0) ? ST_REQ : ST_DONE;
            end
            ST_DONE: begin
                refill_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign refill_err  = err_q;
    assign fetch_stall = busy | miss;

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, SHALL set the number of cycles spent in WAIT without l2_rvalid before a refill aborts.
REQ-002 Parameter LINE_WORDS, default 4, SHALL set the number of 64-bit words per fetch group; only the value 4 is supported.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-low reset.
REQ-005 fetch_valid  in  1  SHALL mean that a fetch lookup is presented this cycle.
REQ-006 fetch_addr  in  64  SHALL carry the base word address of the fetch group.
REQ-007 hit  in  4  SHALL carry the per-word hit vector from the I-cache; bit d covers word fetch_addr+d.
REQ-008 fetch_stall  out  1  SHALL request that the fetch stage hold its address.
REQ-009 l2_req  out  1  SHALL carry the L2 read request level.
REQ-010 l2_addr  out  64  SHALL carry the L2 read word address.
REQ-011 l2_ack  in  1  SHALL signal that L2 accepted the request.
REQ-012 l2_rvalid  in  1  SHALL signal that L2 return data is valid.
REQ-013 l2_rdata  in  64  SHALL carry the L2 return word.
REQ-014 fill_start  out  1  SHALL be a one-cycle I-cache write strobe.
REQ-015 fill_addr  out  64  SHALL carry the write tag (word address).
REQ-016 fill_data  out  64  SHALL carry the write data.
REQ-017 refill_done  out  1  SHALL pulse for one cycle when a refill completes.
REQ-018 refill_err  out  1  SHALL pulse for one cycle when a refill aborts on timeout.
REQ-019 busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT, FILL and DONE.
REQ-021 In IDLE, when fetch_valid=1 and hit!=4'hF, the block SHALL latch base=fetch_addr and miss_mask=~hit, and SHALL go to REQ on the next cycle.
REQ-022 In REQ, the block SHALL select k=lowest set bit of miss_mask, drive l2_req=1 and l2_addr=base+k, and hold both stable until l2_ack=1; when l2_ack=1 it SHALL go to WAIT and clear the timeout counter.
REQ-023 In WAIT, l2_rvalid=1 SHALL capture l2_rdata and go to FILL; otherwise the counter SHALL increment, and on reaching TIMEOUT_CYC-1 the block SHALL pulse refill_err, clear miss_mask and go to IDLE.
REQ-024 In FILL, the block SHALL assert fill_start=1 for exactly one cycle with fill_addr=base+k and fill_data equal to the captured word, and SHALL clear bit k; it SHALL then go to REQ if miss_mask is non-zero, else to DONE.
REQ-025 In DONE, the block SHALL pulse refill_done for one cycle and go to IDLE.
REQ-026 Address arithmetic SHALL be 64-bit modulo 2^64, so base+k wraps past 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-027 fetch_stall SHALL equal (state!=IDLE) | (fetch_valid & (hit!=4'hF)), combinationally.
REQ-028 fetch_valid and hit SHALL be ignored outside IDLE; l2_rvalid SHALL be ignored outside WAIT; l2_ack SHALL be ignored outside REQ.
REQ-029 l2_ack and l2_rvalid arriving in the same REQ cycle SHALL be treated as ack only; the data SHALL be expected in WAIT.
REQ-030 Latency: with l2_ack in the first REQ cycle and l2_rvalid in the first WAIT cycle, each missing word SHALL cost 3 cycles, and refill_done SHALL be asserted one cycle after the last fill_start.

Reset
REQ-031 While reset=0 at a clock edge, the block SHALL set state=IDLE, miss_mask=0, counter=0 and base=0.
REQ-032 While reset=0 at a clock edge, the block SHALL drive l2_req, fill_start, refill_done, refill_err and busy to 0, and l2_addr, fill_addr and fill_data to 0.
REQ-033 A reset in any state, including mid-WAIT, SHALL abandon the refill without a fill_start, refill_done or refill_err pulse.

Structure
REQ-034 The shared package icache_ctrl_pkg SHALL hold the state enum, LINE_WORDS and the default TIMEOUT_CYC.
REQ-035 The lowest-set-bit select SHALL be the single sub-module miss_pri_enc4 (4-bit input, 2-bit index, valid flag).

Verification
REQ-036 Full miss: fetch_addr=0x100, hit=4'b0000, with immediate ack and rvalid -> fill_start at cycles 3, 6, 9 and 12 with fill_addr 0x100..0x103, and refill_done at cycle 13.
REQ-037 Partial miss: hit=4'b1010 -> only addresses base+0 and base+2 requested, in that order, with exactly two fill_start pulses.
REQ-038 All hit: hit=4'hF with fetch_valid=1 -> fetch_stall=0, l2_req never asserted, and busy stays 0.
REQ-039 Timeout: TIMEOUT_CYC=8 with no l2_rvalid -> refill_err pulses exactly once, the FSM returns to IDLE, and there is no fill_start.
REQ-040 Wrap: fetch_addr=64'hFFFF_FFFF_FFFF_FFFE, hit=0 -> l2_addr sequence ...FE, ...FF, 0, 1.
REQ-041 Reset mid-WAIT -> next cycle busy=0, l2_req=0, and no done or err pulse; a later rvalid is ignored.
